// File: rtl/prog_serial_decoder.sv
// Serial programming-line decoder: async frame (idle high, LSB first) -> clamped phase-delay word.
// Optional even-parity bit after data when PROG_PARITY_CHECK_EN is defined.
module prog_serial_decoder #(
  parameter int BIT_CLKS       = 1000,
  parameter int CNT_SIZE       = 10,
  parameter int PROG_NUM_SIZE  = 8,
  parameter int PROG_MAX       = 128,
  parameter int PROG_NUM_RESET = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     progIn,
  output logic [PROG_NUM_SIZE-1:0] progNum,
  output logic                     progStrobe,
  output logic                     frameErr,
  output logic                     busy
);

  localparam int IDX_W = $clog2(PROG_NUM_SIZE + 1);
  localparam logic [CNT_SIZE-1:0]      HALF_LAST = CNT_SIZE'(BIT_CLKS / 2 - 1);
  localparam logic [CNT_SIZE-1:0]      FULL_LAST = CNT_SIZE'(BIT_CLKS - 1);
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(PROG_NUM_SIZE - 1);
  localparam logic [PROG_NUM_SIZE-1:0] MAX_WORD  = PROG_NUM_SIZE'(PROG_MAX);
  localparam logic [PROG_NUM_SIZE-1:0] RST_WORD  = PROG_NUM_SIZE'(PROG_NUM_RESET);

`ifdef PROG_PARITY_CHECK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t                   state, state_nxt;
  logic                     sync_a, prog_sync;
  logic [CNT_SIZE-1:0]      timer;
  logic [IDX_W-1:0]         bit_idx;
  logic [PROG_NUM_SIZE-1:0] shreg;
  logic [PROG_NUM_SIZE-1:0] word_clamped;
  logic                     half_hit, full_hit;
  logic                     sample_now, shift_now, stop_sample;
  logic                     parity_ok, commit, reject;
`ifdef PROG_PARITY_CHECK_EN
  logic                     par_bit;
`endif

  assign half_hit = (timer == HALF_LAST);
  assign full_hit = (timer == FULL_LAST);

  // Two-flop synchronizer; reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a    <= 1'b1;
      prog_sync <= 1'b1;
    end else begin
      sync_a    <= progIn;
      prog_sync <= sync_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!prog_sync) state_nxt = START;
      START:     if (half_hit) state_nxt = prog_sync ? IDLE : DATA;
      DATA: begin
        if (full_hit && (bit_idx == LAST_IDX)) begin
`ifdef PROG_PARITY_CHECK_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef PROG_PARITY_CHECK_EN
      PARITY:    if (full_hit) state_nxt = STOP;
`endif
      // A low stop bit means the line may stay low; wait for idle before re-arming.
      STOP:      if (full_hit) state_nxt = prog_sync ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (prog_sync) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    shift_now   = (state == DATA) && full_hit;
    stop_sample = (state == STOP) && full_hit;
    sample_now  = ((state == START) && half_hit) || shift_now || stop_sample;
`ifdef PROG_PARITY_CHECK_EN
    sample_now  = sample_now || ((state == PARITY) && full_hit);
    parity_ok   = ~(^shreg ^ par_bit);
`else
    parity_ok   = 1'b1;
`endif
    commit       = stop_sample && prog_sync && parity_ok;
    reject       = stop_sample && !commit;
    word_clamped = (shreg > MAX_WORD) ? MAX_WORD : shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE || state == WAIT_IDLE || sample_now) timer <= '0;
      else                                                   timer <= timer + CNT_SIZE'(1);
      if ((state == START) && half_hit) bit_idx <= '0;
      else if (shift_now)               bit_idx <= bit_idx + IDX_W'(1);
      if (shift_now) shreg <= {prog_sync, shreg[PROG_NUM_SIZE-1:1]};
    end
  end

`ifdef PROG_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                              par_bit <= 1'b0;
    else if ((state == PARITY) && full_hit) par_bit <= prog_sync;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      progNum    <= RST_WORD;
      progStrobe <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      if (commit) progNum <= word_clamped;
      progStrobe <= commit;
      frameErr   <= reject;
    end
  end

endmodule

// File: tb/tb_prog_serial_decoder.sv
// Bench for prog_serial_decoder: directed frames with a queue of expected strobe/error events.
module tb_prog_serial_decoder;
  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       progIn = 1'b1;
  logic [7:0] progNum;
  logic       progStrobe, frameErr, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       is_err;
    bit [7:0] val;
  } ev_t;
  ev_t exp_q[$];

  prog_serial_decoder #(
    .BIT_CLKS(BIT), .CNT_SIZE(5), .PROG_NUM_SIZE(8), .PROG_MAX(128), .PROG_NUM_RESET(0)
  ) dut (
    .clk(clk), .rst(rst), .progIn(progIn), .progNum(progNum),
    .progStrobe(progStrobe), .frameErr(frameErr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input bit b);
    progIn = b;
    cyc(BIT);
  endtask

  task automatic send_frame(input bit [7:0] d, input bit stop, input bit par, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef PROG_PARITY_CHECK_EN
    drive_bit(par);
`else
    if (par) begin end
`endif
    drive_bit(stop);
    progIn = 1'b1;
    cyc(gap);
  endtask

  task automatic expect_ev(input bit is_err, input bit [7:0] val);
    ev_t e;
    e.is_err = is_err;
    e.val    = val;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe or error pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (progStrobe || frameErr)) begin
      ev_t e;
      chk("strobe_err_exclusive", int'(progStrobe && frameErr), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_is_err", int'(frameErr), int'(e.is_err));
        chk("event_prognum", int'(progNum), int'(e.val));
      end
    end
  end

  initial begin
    cyc(3);
    chk("reset_prognum", int'(progNum), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_strobe", int'(progStrobe), 0);
    chk("reset_frameerr", int'(frameErr), 0);
    rst = 1'b0;
    cyc(5);

    // 1: plain frame
    expect_ev(1'b0, 8'h40);
    progIn = 1'b0;
    cyc(6);
    chk("busy_in_start", int'(busy), 1);
    cyc(BIT - 6);
    for (int i = 0; i < 8; i++) drive_bit(i == 6);
    drive_bit(1'b1);
    cyc(10);
    chk("prognum_0x40", int'(progNum), 8'h40);

    // 2: short glitch returns to IDLE silently
    progIn = 1'b0;
    cyc(4);
    progIn = 1'b1;
    cyc(20);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_prognum", int'(progNum), 8'h40);

    // 3: bad stop bit, held low, then a good frame
    expect_ev(1'b1, 8'h40);
    send_frame(8'h20, 1'b0, 1'b1, 0);
    progIn = 1'b0;
    cyc(24);
    chk("wait_idle_busy", int'(busy), 1);
    chk("bad_stop_prognum", int'(progNum), 8'h40);
    progIn = 1'b1;
    cyc(6);
    chk("wait_idle_released", int'(busy), 0);
    expect_ev(1'b0, 8'h10);
    send_frame(8'h10, 1'b1, 1'b1, 10);
    chk("prognum_0x10", int'(progNum), 8'h10);

    // 4: clamping and boundary
    expect_ev(1'b0, 8'd128);
    send_frame(8'hC8, 1'b1, 1'b1, 10);
    chk("clamp_200", int'(progNum), 128);
    expect_ev(1'b0, 8'h05);
    send_frame(8'h05, 1'b1, 1'b0, 10);
    expect_ev(1'b0, 8'd128);
    send_frame(8'h80, 1'b1, 1'b1, 10);
    chk("exact_max", int'(progNum), 128);
    expect_ev(1'b0, 8'h05);
    send_frame(8'h05, 1'b1, 1'b0, 10);
    expect_ev(1'b0, 8'd128);
    send_frame(8'h81, 1'b1, 1'b0, 10);
    chk("clamp_129", int'(progNum), 128);

    // back-to-back frames, no idle gap
    expect_ev(1'b0, 8'h7F);
    expect_ev(1'b0, 8'h00);
    expect_ev(1'b0, 8'h33);
    send_frame(8'h7F, 1'b1, 1'b1, 0);
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'h33, 1'b1, 1'b0, 10);
    chk("back_to_back_last", int'(progNum), 8'h33);

`ifdef PROG_PARITY_CHECK_EN
    // 5: even parity
    expect_ev(1'b1, 8'h33);
    send_frame(8'h03, 1'b1, 1'b1, 10);
    chk("bad_parity_prognum", int'(progNum), 8'h33);
    chk("bad_parity_idle", int'(busy), 0);
    expect_ev(1'b0, 8'h03);
    send_frame(8'h03, 1'b1, 1'b0, 10);
    chk("good_parity_prognum", int'(progNum), 8'h03);
`endif

    // 6: reset mid-frame
    expect_ev(1'b0, 8'h40);
    send_frame(8'h40, 1'b1, 1'b1, 10);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    progIn = 1'b0;
    cyc(8);
    chk("busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    progIn = 1'b1;
    cyc(1);
    chk("rst_mid_prognum", int'(progNum), 0);
    chk("rst_mid_busy", int'(busy), 0);
    rst = 1'b0;
    cyc(5);
    expect_ev(1'b0, 8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 10);
    chk("after_rst_prognum", int'(progNum), 8'h5A);

    cyc(50);
    chk("all_events_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
